// File: rtl/alu_pipe_if.sv
// Operand-issue and result-return handshake bundle for alu_pipe.
// master = operand issuer / result consumer side, slave = the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, opcode, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag, flags
    );

    modport slave (
        input  in_valid, a, b, opcode, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with {C,V,N,Z} flags, tag pass-through and valid/ready flow control.
// Optional ALU_PIPE_SAT_EN: ADD saturates to all-ones on carry, SUB saturates to zero on borrow.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_XOR  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_OR   = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [3:0]       s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s1_adv, s2_adv, in_ready, in_fire;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        sum_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        shamt    = s1_b_q[SH_W-1:0];
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (s1_op_q)
            OP_AND:  alu_res = s1_a_q & s1_b_q;
            OP_XOR:  alu_res = s1_a_q ^ s1_b_q;
            OP_ADD: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (s1_a_q[MSB] == s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
`ifdef ALU_PIPE_SAT_EN
                if (alu_c) begin
                    alu_res = '1;
                    alu_v   = 1'b0;
                end
`endif
            end
            OP_SUB: begin
                alu_res = diff_ext[MSB:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (s1_a_q[MSB] != s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
`ifdef ALU_PIPE_SAT_EN
                if (alu_c) begin
                    alu_res = '0;
                    alu_v   = 1'b0;
                end
`endif
            end
            OP_OR:   alu_res = s1_a_q | s1_b_q;
            OP_SHL:  alu_res = s1_a_q << shamt;
            OP_SHR:  alu_res = s1_a_q >> shamt;
            OP_PASS: alu_res = s1_b_q;
            default: alu_res = '0;
        endcase
    end

    // A stage advances when empty or when the stage after it advances this cycle.
    always_comb begin
        s2_adv   = !s2_valid_q || bus.out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = !rst && s1_adv;
        in_fire  = bus.in_valid && in_ready;

        s1_valid_d = s1_adv ? in_fire : s1_valid_q;
        s1_a_d     = in_fire ? bus.a : s1_a_q;
        s1_b_d     = in_fire ? bus.b : s1_b_q;
        s1_op_d    = in_fire ? op_e'(bus.opcode) : s1_op_q;
        s1_tag_d   = in_fire ? bus.in_tag : s1_tag_q;

        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        s2_tag_d    = s2_tag_q;
        if (s2_adv && s1_valid_q) begin
            s2_result_d = alu_res;
            s2_flags_d  = {alu_c, alu_v, alu_res[MSB], alu_res == '0};
            s2_tag_d    = s1_tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_AND;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = s2_result_q;
    assign bus.flags     = s2_flags_q;
    assign bus.out_tag   = s2_tag_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomised-handshake checks of alu_pipe at WIDTH=8, TAG_W=4.
// Expected values are hand-computed or come from an integer reference model; honours ALU_PIPE_SAT_EN.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8), .TAG_W(4)) bus ();

    alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [3:0] t);
        bus.a        = a;
        bus.b        = b;
        bus.opcode   = op;
        bus.in_tag   = t;
        bus.in_valid = 1'b1;
    endtask

    // Returns {flags[3:0], result[7:0]}; arithmetic done on plain ints.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        int ia = int'(a);
        int ib = int'(b);
        int sa = (ia > 127) ? ia - 256 : ia;
        int sb = (ib > 127) ? ib - 256 : ib;
        int r = 0;
        int sr;
        logic c = 1'b0;
        logic v = 1'b0;
        case (op)
            3'd0: r = ia & ib;
            3'd1: r = ia ^ ib;
            3'd2: begin
                r  = ia + ib;
                sr = sa + sb;
                c  = (r > 255);
                v  = (sr > 127) || (sr < -128);
                r  = r % 256;
`ifdef ALU_PIPE_SAT_EN
                if (c) begin r = 255; v = 1'b0; end
`endif
            end
            3'd3: begin
                r  = ia - ib;
                sr = sa - sb;
                c  = (r < 0);
                v  = (sr > 127) || (sr < -128);
                r  = (r + 256) % 256;
`ifdef ALU_PIPE_SAT_EN
                if (c) begin r = 0; v = 1'b0; end
`endif
            end
            3'd4: r = ia | ib;
            3'd5: r = (ia * (1 << (ib % 8))) % 256;
            3'd6: r = ia / (1 << (ib % 8));
            default: r = ib;
        endcase
        return {c, v, (r >= 128), (r == 0), 8'(r)};
    endfunction

    // One isolated op with out_ready=1: accept, one cycle in S1, then visible on the output.
    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [3:0] t,
                           input logic [7:0] er, input logic [3:0] ef);
        @(negedge clk);
        drive(a, b, op, t);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk(tag, {15'd0, bus.out_valid, bus.out_tag, bus.flags, bus.result}, {15'd0, 1'b1, t, ef, er});
    endtask

    logic [7:0]  leg_r[4];
    logic [3:0]  leg_f[4];
    logic [15:0] exp_q[$];
    logic [15:0] exp_beat;
    logic [7:0]  ra, rb;
    logic [2:0]  rop;
    logic [3:0]  rtag;
    logic [7:0]  sub_r;
    logic [3:0]  sub_f;
    int          accepted, got, sent, recv, cyc;
    logic        pend;

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_out", {15'd0, bus.out_valid, bus.out_tag, bus.flags, bus.result}, 32'd0);
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        #1 chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Legacy ops back-to-back: DA op AA for op 000..011
        leg_r = '{8'h8A, 8'h70, 8'h84, 8'h30};
        leg_f = '{4'b0010, 4'b0000, 4'b1010, 4'b0000};
`ifdef ALU_PIPE_SAT_EN
        leg_r[2] = 8'hFF;
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2)
                chk($sformatf("legacy_%0d", i - 2),
                    {15'd0, bus.out_valid, bus.out_tag, bus.flags, bus.result},
                    {15'd0, 1'b1, 4'(i - 2), leg_f[i-2], leg_r[i-2]});
            else
                chk($sformatf("legacy_lat_%0d", i), {31'd0, bus.out_valid}, 32'd0);
            if (i < 4) drive(8'hDA, 8'hAA, 3'(i), 4'(i));
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("legacy_drained", {31'd0, bus.out_valid}, 32'd0);

        // New ops and flags
        run_one("or",       8'h0F, 8'hF0, 3'b100, 4'h5, 8'hFF, 4'b0010);
        run_one("shl",      8'h01, 8'h03, 3'b101, 4'h6, 8'h08, 4'b0000);
        run_one("shr",      8'h80, 8'h07, 3'b110, 4'h7, 8'h01, 4'b0000);
        run_one("shl_wrap", 8'h01, 8'h09, 3'b101, 4'h8, 8'h02, 4'b0000);
        run_one("shr_wrap", 8'h80, 8'h0F, 3'b110, 4'h3, 8'h01, 4'b0000);
        run_one("pass",     8'h55, 8'h00, 3'b111, 4'h9, 8'h00, 4'b0001);
        run_one("add_ovf",  8'h7F, 8'h01, 3'b010, 4'hA, 8'h80, 4'b0110);
`ifdef ALU_PIPE_SAT_EN
        sub_r = 8'h00; sub_f = 4'b1001;
`else
        sub_r = 8'hF0; sub_f = 4'b1010;
`endif
        run_one("sub_borrow", 8'h10, 8'h20, 3'b011, 4'hB, sub_r, sub_f);
        run_one("sub_zero",   8'h42, 8'h42, 3'b011, 4'hC, 8'h00, 4'b0001);

        // Backpressure: out_ready low for 5 cycles while 4 ADDs are offered
        accepted = 0;
        got      = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 5);
            if (accepted < 4) drive(8'h10 + 8'(accepted), 8'h01, 3'b010, 4'(accepted));
            else bus.in_valid = 1'b0;
            #1;
            if (c == 2) begin
                chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
                chk("bp_accepts", 32'(accepted), 32'd2);
            end
            if (c >= 2 && c < 5)
                chk($sformatf("bp_hold_%0d", c),
                    {15'd0, bus.out_valid, bus.out_tag, bus.flags, bus.result},
                    {15'd0, 1'b1, 4'd0, 4'b0000, 8'h11});
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("bp_out_%0d", got), {20'd0, bus.out_tag, bus.result},
                    {20'd0, 4'(got), 8'h11 + 8'(got)});
                got++;
            end
            if (bus.in_valid && bus.in_ready) accepted++;
        end
        chk("bp_count", 32'(got), 32'd4);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Random valid/ready toggling against the reference model
        pend = 1'b0;
        sent = 0;
        recv = 0;
        cyc  = 0;
        ra = '0; rb = '0; rop = '0; rtag = '0;
        while (recv < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < 1000 && $urandom_range(3) != 0) begin
                ra   = 8'($urandom);
                rb   = 8'($urandom);
                rop  = 3'($urandom);
                rtag = 4'(sent);
                pend = 1'b1;
            end
            bus.a        = ra;
            bus.b        = rb;
            bus.opcode   = rop;
            bus.in_tag   = rtag;
            bus.in_valid = pend && ($urandom_range(4) != 0);
            bus.out_ready = ($urandom_range(2) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("rand_beat", {16'd0, bus.out_tag, bus.flags, bus.result}, {16'd0, exp_beat});
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({rtag, model(ra, rb, rop)});
                pend = 1'b0;
                sent++;
            end
        end
        chk("rand_received", 32'(recv), 32'd1000);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset with two ops in flight
        @(negedge clk);
        drive(8'h05, 8'h03, 3'b010, 4'hD);
        @(negedge clk);
        drive(8'h0F, 8'h01, 3'b001, 4'hE);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out", {15'd0, bus.out_valid, bus.out_tag, bus.flags, bus.result}, 32'd0);
        chk("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(8'h21, 8'h12, 3'b010, 4'h4);
        #1 chk("post_reset_accept", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("post_reset_no_ghost", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("post_reset_op", {15'd0, bus.out_valid, bus.out_tag, bus.flags, bus.result},
            {15'd0, 1'b1, 4'h4, 4'b0000, 8'h33});
        @(negedge clk);
        chk("post_reset_drained", {31'd0, bus.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
